// File: rtl/fetch_unit.sv
// IF stage: PC, one-deep fetch buffer and a req/ack port to imem. The IF/ID write comes 1 cycle after ack at the earliest.
// A stall holds the buffer and issues no new request once the buffer is full. A redirect flushes the buffer and drains any in-flight response.
module fetch_unit #(
    parameter int              PC_W     = 8,
    parameter int              INSTR_W  = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              PC_INC   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall_i,
    input  logic               redirect_i,
    input  logic [PC_W-1:0]    redirect_pc_i,
    output logic               imem_req_o,
    output logic [PC_W-1:0]    imem_addr_o,
    input  logic               imem_ack_i,
    input  logic [INSTR_W-1:0] imem_rdata_i,
    output logic [PC_W-1:0]    if_pc_o,
    output logic [INSTR_W-1:0] if_instr_o,
    output logic               if_we_o
);
    localparam logic [0:0] S_FETCH = 1'b0;
    localparam logic [0:0] S_DRAIN = 1'b1;

    logic [0:0]         state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [PC_W-1:0]    addr_q, addr_d;
    logic               pend_q, pend_d;
    logic               buf_valid_q, buf_valid_d;
    logic [PC_W-1:0]    buf_pc_q, buf_pc_d;
    logic [INSTR_W-1:0] buf_instr_q, buf_instr_d;

    logic               deliver;
    logic               new_req;
    logic               req;
    logic               ack;
    logic [PC_W-1:0]    cur_addr;

    // A new request may only start when nothing is in flight; its address
    // is pc on the first cycle and the latched addr_q while it waits for ack.
    always_comb begin
        deliver  = buf_valid_q & ~stall_i & ~redirect_i;
        new_req  = (state_q == S_FETCH) & ~pend_q & (~buf_valid_q | deliver);
        req      = rst_n & (pend_q | new_req);
        ack      = imem_ack_i & req;
        cur_addr = pend_q ? addr_q : pc_q;
    end

    assign imem_req_o  = req;
    assign imem_addr_o = cur_addr;
    assign if_we_o     = deliver;
    assign if_pc_o     = buf_pc_q;
    assign if_instr_o  = buf_instr_q;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        addr_d      = addr_q;
        pend_d      = req & ~ack;
        buf_valid_d = buf_valid_q;
        buf_pc_d    = buf_pc_q;
        buf_instr_d = buf_instr_q;

        if (req && !pend_q) begin
            addr_d = pc_q;
        end

        if (redirect_i) begin
            pc_d        = redirect_pc_i;
            buf_valid_d = 1'b0;
            if (req && !ack) begin
                state_d = S_DRAIN;
            end
        end else if (state_q == S_FETCH) begin
            if (ack) begin
                buf_valid_d = 1'b1;
                buf_pc_d    = cur_addr;
                buf_instr_d = imem_rdata_i;
                pc_d        = pc_q + PC_W'(PC_INC);
            end else if (deliver) begin
                buf_valid_d = 1'b0;
            end
        end

        // The stale response finishes the drain even if another redirect lands with it.
        if (state_q == S_DRAIN && ack) begin
            state_d = S_FETCH;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_PC;
            addr_q      <= RESET_PC;
            pend_q      <= 1'b0;
            buf_valid_q <= 1'b0;
            buf_pc_q    <= '0;
            buf_instr_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            addr_q      <= addr_d;
            pend_q      <= pend_d;
            buf_valid_q <= buf_valid_d;
            buf_pc_q    <= buf_pc_d;
            buf_instr_q <= buf_instr_d;
        end
    end
endmodule
